bwt_req_arbiter: RTL and testbench



---
 rtl/bwt_arb_pkg.sv | 27 ++
 rtl/bwt_req_fifo.sv | 51 +++++
 rtl/bwt_req_arbiter.sv | 153 +++++++++++++++
 tb/tb_bwt_req_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bwt_arb_pkg.sv
// rtl/bwt_arb_pkg.sv - shared constants, FSM encoding and helpers for the BWT request arbiter
package bwt_arb_pkg;

    localparam logic SRC_F = 1'b0;
    localparam logic SRC_B = 1'b1;
    localparam logic KL_K  = 1'b0;
    localparam logic KL_L  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_K = 2'd1,
        SEND_L = 2'd2
    } arb_state_t;

    function automatic int entry_width(input int addr_w, input int rn_w);
        return 2 * addr_w + rn_w;
    endfunction

    // Round-robin pick: on a tie the source that was not served last wins.
    function automatic logic pick_src(input logic ne_f, input logic ne_b, input logic rr_last);
        if (ne_f && ne_b) begin
            return ~rr_last;
        end
        return (ne_b && !ne_f) ? SRC_B : SRC_F;
    endfunction

endpackage

// File: rtl/bwt_req_fifo.sv
// rtl/bwt_req_fifo.sv - synchronous FIFO with occupancy count and head/next-head peek
module bwt_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [W-1:0]  next_head,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    // A push into a full FIFO is dropped even if a pop happens on the same edge.
    assign wr_en      = push && (count != FULL_CNT);
    assign rd_en      = pop && (count != '0);
    assign count_next = count + CW'(wr_en) - CW'(rd_en);
    assign head       = mem[rd_ptr];
    assign next_head  = mem[rd_ptr + AW'(1)];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
        end
    end

endmodule

// File: rtl/bwt_req_arbiter.sv
// rtl/bwt_req_arbiter.sv - round-robin arbiter serialising forward/backward k/l requests onto one memory port
module bwt_req_arbiter
    import bwt_arb_pkg::*;
#(
    parameter int ADDR_W = 42,
    parameter int RN_W   = 9,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_f,
    input  logic [ADDR_W-1:0] addr_k_f,
    input  logic [ADDR_W-1:0] addr_l_f,
    input  logic [RN_W-1:0]   read_num_f,
    input  logic              req_valid_b,
    input  logic [ADDR_W-1:0] addr_k_b,
    input  logic [ADDR_W-1:0] addr_l_b,
    input  logic [RN_W-1:0]   read_num_b,
    output logic              stall_f,
    output logic              stall_b,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [RN_W+1:0]   mem_req_tag,
    output logic [1:0]        overflow_err,
    output logic              arb_idle
);
    localparam int EW = entry_width(ADDR_W, RN_W);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 1);

    logic [EW-1:0] head_f, head_b, next_f, next_b, ent;
    logic [CW-1:0] count_f, count_b, count_next_f, count_next_b;
    logic          pop_f, pop_b, ne_f, ne_b, post_f, post_b, sel;

    arb_state_t        state_q, state_d;
    logic              src_q, src_d, kl_q, kl_d, valid_q, valid_d, rr_q, rr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RN_W-1:0]   rn_q, rn_d;

    bwt_req_fifo #(.W(EW), .DEPTH(DEPTH), .CW(CW)) u_fifo_f (
        .clk(clk), .rst(rst), .push(req_valid_f),
        .push_data({addr_k_f, addr_l_f, read_num_f}), .pop(pop_f),
        .head(head_f), .next_head(next_f), .count(count_f), .count_next(count_next_f)
    );

    bwt_req_fifo #(.W(EW), .DEPTH(DEPTH), .CW(CW)) u_fifo_b (
        .clk(clk), .rst(rst), .push(req_valid_b),
        .push_data({addr_k_b, addr_l_b, read_num_b}), .pop(pop_b),
        .head(head_b), .next_head(next_b), .count(count_b), .count_next(count_next_b)
    );

    assign ne_f          = (count_f != '0);
    assign ne_b          = (count_b != '0);
    assign mem_req_valid = valid_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_tag   = {src_q, kl_q, rn_q};
    assign arb_idle      = !ne_f && !ne_b && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        kl_d    = kl_q;
        addr_d  = addr_q;
        rn_d    = rn_q;
        valid_d = valid_q;
        rr_d    = rr_q;
        pop_f   = 1'b0;
        pop_b   = 1'b0;
        post_f  = ne_f;
        post_b  = ne_b;
        sel     = SRC_F;
        ent     = head_f;
        case (state_q)
            IDLE: begin
                if (ne_f || ne_b) begin
                    sel     = pick_src(ne_f, ne_b, rr_q);
                    ent     = sel ? head_b : head_f;
                    addr_d  = ent[EW-1 -: ADDR_W];
                    rn_d    = ent[RN_W-1:0];
                    src_d   = sel;
                    kl_d    = KL_K;
                    valid_d = 1'b1;
                    state_d = SEND_K;
                end
            end
            SEND_K: begin
                if (mem_req_ready) begin
                    ent     = src_q ? head_b : head_f;
                    addr_d  = ent[RN_W +: ADDR_W];
                    kl_d    = KL_L;
                    state_d = SEND_L;
                end
            end
            SEND_L: begin
                if (mem_req_ready) begin
                    pop_f  = (src_q == SRC_F);
                    pop_b  = (src_q == SRC_B);
                    rr_d   = src_q;
                    post_f = (src_q == SRC_F) ? (count_f > CW'(1)) : ne_f;
                    post_b = (src_q == SRC_B) ? (count_b > CW'(1)) : ne_b;
                    if (post_f || post_b) begin
                        // Re-serving the popped source means its second entry is the new head.
                        sel     = pick_src(post_f, post_b, src_q);
                        ent     = (sel == src_q) ? (sel ? next_b : next_f)
                                                 : (sel ? head_b : head_f);
                        addr_d  = ent[EW-1 -: ADDR_W];
                        rn_d    = ent[RN_W-1:0];
                        src_d   = sel;
                        kl_d    = KL_K;
                        state_d = SEND_K;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            src_q        <= SRC_F;
            kl_q         <= KL_K;
            addr_q       <= '0;
            rn_q         <= '0;
            valid_q      <= 1'b0;
            rr_q         <= SRC_B;
            stall_f      <= 1'b0;
            stall_b      <= 1'b0;
            overflow_err <= 2'b00;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            kl_q         <= kl_d;
            addr_q       <= addr_d;
            rn_q         <= rn_d;
            valid_q      <= valid_d;
            rr_q         <= rr_d;
            stall_f      <= (count_next_f >= STALL_CNT);
            stall_b      <= (count_next_b >= STALL_CNT);
            overflow_err <= overflow_err | {req_valid_b && (count_b == FULL_CNT),
                                            req_valid_f && (count_f == FULL_CNT)};
        end
    end

endmodule

// File: tb/tb_bwt_req_arbiter.sv
// tb/tb_bwt_req_arbiter.sv - scoreboard bench for bwt_req_arbiter against a queue-based reference model
module tb_bwt_req_arbiter;
    localparam int AW = 42;
    localparam int RW = 9;
    localparam int D  = 4;

    typedef struct {
        logic [AW-1:0] k;
        logic [AW-1:0] l;
        logic [RW-1:0] rn;
    } entry_t;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [RW+1:0]   tag;
    } xfer_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid_f = 1'b0, req_valid_b = 1'b0;
    logic [AW-1:0] addr_k_f = '0, addr_l_f = '0, addr_k_b = '0, addr_l_b = '0;
    logic [RW-1:0] read_num_f = '0, read_num_b = '0;
    logic          stall_f, stall_b, mem_req_valid, arb_idle;
    logic          mem_req_ready = 1'b0;
    logic [AW-1:0] mem_req_addr;
    logic [RW+1:0] mem_req_tag;
    logic [1:0]    overflow_err;

    int checks   = 0;
    int failures = 0;

    entry_t mq_f[$];
    entry_t mq_b[$];
    xfer_t  sb[$];
    bit     m_active, m_phase, m_src, m_rr, m_stall_f, m_stall_b;
    bit [1:0] m_ovf;

    bwt_req_arbiter #(.ADDR_W(AW), .RN_W(RW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .req_valid_f(req_valid_f), .addr_k_f(addr_k_f), .addr_l_f(addr_l_f), .read_num_f(read_num_f),
        .req_valid_b(req_valid_b), .addr_k_b(addr_k_b), .addr_l_b(addr_l_b), .read_num_b(read_num_b),
        .stall_f(stall_f), .stall_b(stall_b),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .overflow_err(overflow_err), .arb_idle(arb_idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq_f.delete();
        mq_b.delete();
        sb.delete();
        m_active  = 0;
        m_phase   = 0;
        m_src     = 0;
        m_rr      = 1;
        m_stall_f = 0;
        m_stall_b = 0;
        m_ovf     = 2'b00;
    endtask

    // One clock edge of the reference: finish a pair, pick the next one, then enqueue new requests.
    task automatic model_edge();
        int     nf = mq_f.size();
        int     nb = mq_b.size();
        bit     free = !m_active;
        bit     fne, bne, s;
        entry_t e;
        if (m_active && mem_req_ready) begin
            if (m_phase) begin
                if (m_src) void'(mq_b.pop_front());
                else       void'(mq_f.pop_front());
                m_rr     = m_src;
                m_active = 0;
                free     = 1;
            end else begin
                m_phase = 1;
            end
        end
        if (free) begin
            fne = mq_f.size() > 0;
            bne = mq_b.size() > 0;
            if (fne || bne) begin
                s = (fne && bne) ? !m_rr : !fne;
                e = s ? mq_b[0] : mq_f[0];
                sb.push_back('{addr: e.k, tag: {s, 1'b0, e.rn}});
                sb.push_back('{addr: e.l, tag: {s, 1'b1, e.rn}});
                m_active = 1;
                m_phase  = 0;
                m_src    = s;
            end
        end
        if (req_valid_f) begin
            if (nf == D) m_ovf[0] = 1;
            else mq_f.push_back('{k: addr_k_f, l: addr_l_f, rn: read_num_f});
        end
        if (req_valid_b) begin
            if (nb == D) m_ovf[1] = 1;
            else mq_b.push_back('{k: addr_k_b, l: addr_l_b, rn: read_num_b});
        end
        m_stall_f = mq_f.size() >= D - 1;
        m_stall_b = mq_b.size() >= D - 1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        #1;
    endtask

    task automatic set_req(input bit vf, input bit vb, input bit rdy);
        req_valid_f   = vf;
        req_valid_b   = vb;
        mem_req_ready = rdy;
        addr_k_f      = {10'($urandom), 32'($urandom)};
        addr_l_f      = {10'($urandom), 32'($urandom)};
        read_num_f    = 9'($urandom);
        addr_k_b      = {10'($urandom), 32'($urandom)};
        addr_l_b      = {10'($urandom), 32'($urandom)};
        read_num_b    = 9'($urandom);
    endtask

    always @(negedge clk) begin
        chk("valid", 64'(mem_req_valid), 64'(m_active));
        if (mem_req_valid) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 64'(0), 64'(1));
            end else begin
                chk("addr", 64'(mem_req_addr), 64'(sb[0].addr));
                chk("tag", 64'(mem_req_tag), 64'(sb[0].tag));
                if (mem_req_ready) void'(sb.pop_front());
            end
        end
        chk("stall_f", 64'(stall_f), 64'(m_stall_f));
        chk("stall_b", 64'(stall_b), 64'(m_stall_b));
        chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
        chk("arb_idle", 64'(arb_idle), 64'(mq_f.size() == 0 && mq_b.size() == 0 && !m_active));
    end

    initial begin
        bit reached;
        model_reset();
        #2;
        chk("rst_valid", 64'(mem_req_valid), 64'(0));
        chk("rst_idle", 64'(arb_idle), 64'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // Single forward request.
        set_req(1, 0, 1);
        addr_k_f = 42'h100; addr_l_f = 42'h180; read_num_f = 9'd5;
        tick();
        set_req(0, 0, 1);
        for (int i = 0; i < 5; i++) tick();

        // Simultaneous pushes, twice.
        for (int r = 0; r < 2; r++) begin
            set_req(1, 1, 1);
            read_num_f = 9'd1; read_num_b = 9'd2;
            tick();
            set_req(0, 0, 1);
            for (int i = 0; i < 6; i++) tick();
        end

        // Backpressure in SEND_K, then a single ready pulse.
        set_req(1, 0, 0);
        tick();
        set_req(0, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Fill the forward FIFO with ready low.
        for (int i = 0; i < 5; i++) begin
            set_req(1, 0, 0);
            tick();
        end
        set_req(0, 0, 0);
        tick();
        chk("fill_overflow", 64'(overflow_err), 64'(2'b01));
        mem_req_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b0;
        model_reset();
        tick();
        rst = 1'b1;
        tick();

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            set_req($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 70);
            tick();
        end

        // Reach SEND_L with three entries queued, then reset asynchronously.
        set_req(0, 0, 1);
        for (int i = 0; i < 30; i++) tick();
        for (int i = 0; i < 3; i++) begin
            set_req(1, 0, 0);
            tick();
        end
        set_req(0, 0, 0);
        reached = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_active && m_phase) begin
                reached = 1;
                break;
            end
            mem_req_ready = m_active && !m_phase;
            tick();
        end
        chk("reach_send_l", 64'(reached), 64'(1));
        #2;
        mem_req_ready = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_valid", 64'(mem_req_valid), 64'(0));
        chk("async_stall_f", 64'(stall_f), 64'(0));
        chk("async_idle", 64'(arb_idle), 64'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        set_req(0, 0, 1);
        for (int i = 0; i < 10; i++) tick();

        set_req(0, 0, 1);
        for (int i = 0; i < 20; i++) tick();
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
